// File: rtl/systolic_mem_sched_pkg.sv
// systolic_pkg: mode/state encodings and address-constant defaults shared by
// the systolic_mem_sched scheduler and its address generator.
package systolic_pkg;
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_AS   = 2'd1,
        MODE_SA   = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_FREE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SAVE  = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    localparam int STRIDE_A_DEF = 21504;
    localparam int STRIDE_S_DEF = 10752;
    localparam int LINE_A_DEF   = 64;
    localparam int LINE_S_DEF   = 32;
    localparam int BASE_B_DEF   = 86016;
    localparam int ROW_B_DEF    = 128;
endpackage

// File: rtl/systolic_mem_sched_if.sv
// systolic_mem_sched_if: control, memory and array-operand signals of the scheduler.
// slave is the scheduler side, master the environment side.
interface systolic_mem_sched_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic              start;
    logic [1:0]        mode;
    logic              abort;
    logic              hash_ready;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] acc_in;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_s;
    logic              wen_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] data_left;
    logic [DATA_W-1:0] data_right;
    logic              sys_valid;
    logic              sys_mode;
    logic              trans_sel;
    logic              busy;
    logic              done;

    modport slave (
        input  start, mode, abort, hash_ready, rd_data_a, rd_data_s, acc_in,
        output addr_a, addr_s, wen_s, wr_data_s, data_left, data_right,
               sys_valid, sys_mode, trans_sel, busy, done
    );

    modport master (
        output start, mode, abort, hash_ready, rd_data_a, rd_data_s, acc_in,
        input  addr_a, addr_s, wen_s, wr_data_s, data_left, data_right,
               sys_valid, sys_mode, trans_sel, busy, done
    );
endinterface

// File: rtl/systolic_mem_sched_addr_gen.sv
// sched_addr_gen: combinational A/S memory addresses from the tile, line and
// block counters; streaming addresses in FEED, write-back addresses in SAVE.
module sched_addr_gen import systolic_pkg::*; #(
    parameter int ADDR_W   = 32,
    parameter int TILE     = 4,
    parameter int TW       = 2,
    parameter int STRIDE_A = STRIDE_A_DEF,
    parameter int STRIDE_S = STRIDE_S_DEF,
    parameter int LINE_A   = LINE_A_DEF,
    parameter int LINE_S   = LINE_S_DEF,
    parameter int BASE_B   = BASE_B_DEF,
    parameter int ROW_B    = ROW_B_DEF
) (
    input  logic              feed,
    input  logic              save,
    input  logic [TW-1:0]     tile,
    input  logic [ADDR_W-1:0] line,
    input  logic [ADDR_W-1:0] blk,
    input  logic [ADDR_W-1:0] k,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_s
);
    logic [ADDR_W-1:0] t, a_feed, s_feed, s_save;

    always_comb begin
        t      = ADDR_W'(tile);
        a_feed = line * ADDR_W'(LINE_A) + t * ADDR_W'(STRIDE_A);
        s_feed = line * ADDR_W'(LINE_S) + t * ADDR_W'(STRIDE_S)
               + (blk[0] ? ADDR_W'(TILE * STRIDE_S) : '0);
        // Rows are written back bottom-up: k=0 targets row TILE-1.
        s_save = ADDR_W'(BASE_B) + (blk >> 1) * ADDR_W'(TILE * ROW_B)
               + (blk[0] ? ADDR_W'(LINE_A) : '0)
               + (ADDR_W'(TILE - 1) - k) * ADDR_W'(ROW_B);
        addr_a = feed ? a_feed : '0;
        addr_s = feed ? s_feed : save ? s_save : '0;
    end
endmodule

// File: rtl/systolic_mem_sched.sv
// systolic_mem_sched: streams A/S memory tiles into a systolic array and writes
// accumulated results back to S memory. SYSTOLIC_MEM_SCHED_PERF_EN adds stall_cnt.
module systolic_mem_sched import systolic_pkg::*; #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 32,
    parameter int TILE     = 4,
    parameter int N_LINES  = 336,
    parameter int DRAIN    = 2,
    parameter int N_BLK    = 2,
    parameter int STRIDE_A = STRIDE_A_DEF,
    parameter int STRIDE_S = STRIDE_S_DEF,
    parameter int LINE_A   = LINE_A_DEF,
    parameter int LINE_S   = LINE_S_DEF,
    parameter int BASE_B   = BASE_B_DEF,
    parameter int ROW_B    = ROW_B_DEF
) (
    input logic clk,
    input logic rst_n,
    systolic_mem_sched_if.slave bus
`ifdef SYSTOLIC_MEM_SCHED_PERF_EN
    , output logic [31:0] stall_cnt
`endif
);
    localparam int TW = (TILE > 1) ? $clog2(TILE) : 1;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [TW-1:0]     tile_q, tile_d;
    logic [ADDR_W-1:0] line_q, line_d, blk_q, blk_d, cyc_q, cyc_d, blk_inc;
    logic              trans_q, trans_d, done_q, done_d, prev_feed_q, prev_feed_d;
    logic              feed, drain, save, tile_last, start_ok, blk_last;

    always_comb begin
        feed      = state_q == ST_FEED;
        drain     = state_q == ST_DRAIN;
        save      = state_q == ST_SAVE;
        tile_last = tile_q == TW'(TILE - 1);
        blk_inc   = blk_q + ADDR_W'(1);
        blk_last  = blk_q == ADDR_W'(N_BLK - 1);
        start_ok  = state_q == ST_FREE && bus.start && !bus.abort
                 && (bus.mode == MODE_AS || bus.mode == MODE_SA);
        prev_feed_d = feed;
        state_d = state_q;
        mode_d  = mode_q;
        tile_d  = tile_q;
        line_d  = line_q;
        blk_d   = blk_q;
        cyc_d   = cyc_q;
        trans_d = trans_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = ST_FREE;
        end else begin
            if (feed || drain || save) tile_d = tile_last ? '0 : tile_q + TW'(1);
            if ((feed || drain) && tile_q == '0) trans_d = ~trans_q;
            case (state_q)
                ST_FREE: if (start_ok) begin
                    state_d = ST_FEED;
                    mode_d  = mode_e'(bus.mode);
                    tile_d  = '0;
                    line_d  = '0;
                    blk_d   = '0;
                    cyc_d   = '0;
                    trans_d = 1'b1;
                end
                ST_FEED: if (tile_last) begin
                    line_d = line_q + ADDR_W'(1);
                    if (line_q == ADDR_W'(N_LINES - 1)) begin
                        state_d = ST_DRAIN;
                        cyc_d   = '0;
                    end
                end
                ST_DRAIN: begin
                    cyc_d = cyc_q + ADDR_W'(1);
                    if (cyc_q == ADDR_W'(DRAIN * TILE - 1)) begin
                        state_d = ST_SAVE;
                        cyc_d   = '0;
                    end
                end
                ST_SAVE: if (cyc_q == ADDR_W'(2 * TILE - 1)) begin
                    // Odd blocks reuse the hash already delivered for their even partner.
                    blk_d   = blk_inc;
                    done_d  = blk_last;
                    state_d = blk_last ? ST_FREE : (bus.hash_ready || blk_inc[0]) ? ST_FEED : ST_WAIT;
                    line_d  = '0;
                    tile_d  = '0;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + ADDR_W'(1);
                end
                ST_WAIT: if (bus.hash_ready || blk_q[0]) begin
                    state_d = ST_FEED;
                    line_d  = '0;
                    tile_d  = '0;
                end
                default: state_d = ST_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FREE;
            mode_q      <= MODE_IDLE;
            tile_q      <= '0;
            line_q      <= '0;
            blk_q       <= '0;
            cyc_q       <= '0;
            trans_q     <= 1'b1;
            done_q      <= 1'b0;
            prev_feed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            tile_q      <= tile_d;
            line_q      <= line_d;
            blk_q       <= blk_d;
            cyc_q       <= cyc_d;
            trans_q     <= trans_d;
            done_q      <= done_d;
            prev_feed_q <= prev_feed_d;
        end
    end

    sched_addr_gen #(
        .ADDR_W(ADDR_W), .TILE(TILE), .TW(TW), .STRIDE_A(STRIDE_A), .STRIDE_S(STRIDE_S),
        .LINE_A(LINE_A), .LINE_S(LINE_S), .BASE_B(BASE_B), .ROW_B(ROW_B)
    ) u_addr (
        .feed(feed), .save(save), .tile(tile_q), .line(line_q), .blk(blk_q),
        .k(cyc_q >> 1), .addr_a(bus.addr_a), .addr_s(bus.addr_s)
    );

    // Read data lags the address by one cycle, hence prev_feed_q gates the operands.
    assign bus.data_left  = !prev_feed_q ? '0 : (mode_q == MODE_SA) ? bus.rd_data_s : bus.rd_data_a;
    assign bus.data_right = !prev_feed_q ? '0 : (mode_q == MODE_SA) ? bus.rd_data_a : bus.rd_data_s;
    assign bus.wen_s      = save && cyc_q[0] && !bus.abort;
    assign bus.wr_data_s  = save ? bus.rd_data_s + bus.acc_in : '0;
    assign bus.sys_valid  = feed || drain;
    assign bus.sys_mode   = mode_q == MODE_AS;
    assign bus.trans_sel  = trans_q;
    assign bus.busy       = state_q != ST_FREE;
    assign bus.done       = done_q;

`ifdef SYSTOLIC_MEM_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;
    always_comb stall_d = start_ok ? '0 : (state_q == ST_WAIT && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else stall_q <= stall_d;
    end
    assign stall_cnt = stall_q;
`endif
endmodule
